// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline slice.
//   XLEN       : datapath width
//   REG_ADDR_W : register-file address width
package mips_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, combinational read, no reset.
//   clk   : write clock
//   we    : write enable (already qualified by the caller)
//   addr  : word index
//   wdata : write data
//   rdata : combinational read of the addressed word (pre-write value on a write edge)
module data_mem
  import mips_pkg::*;
#(
  parameter int unsigned DM_WORDS = 256,
  parameter int unsigned AW       = $clog2(DM_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline latch.
//   Inputs  : EX/MEM latch fields (*_EX), stall, clk, rst_n (async, active-low)
//   Outputs : MEM/WB latch (busW_WB, RW_WB, RegWrite_WB), branch redirect
//             (branch_taken, branch_target), MEM-stage forwarding
//             (fwd_en_MEM, fwd_RW_MEM, fwd_data_MEM), sticky align_err
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned DM_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       PCnew_EX,
  input  logic [XLEN-1:0]       out_EX,
  input  logic [XLEN-1:0]       busB_EX,
  input  logic [REG_ADDR_W-1:0] RW_EX,
  input  logic                  zero_EX,
  input  logic                  nPC_sel_EX,
  input  logic                  MemWrite_EX,
  input  logic                  MemtoReg_EX,
  input  logic                  RegWrite_EX,
  input  logic                  stall,
  output logic [XLEN-1:0]       busW_WB,
  output logic [REG_ADDR_W-1:0] RW_WB,
  output logic                  RegWrite_WB,
  output logic                  branch_taken,
  output logic [XLEN-1:0]       branch_target,
  output logic                  fwd_en_MEM,
  output logic [REG_ADDR_W-1:0] fwd_RW_MEM,
  output logic [XLEN-1:0]       fwd_data_MEM,
  output logic                  align_err
);

  localparam int unsigned AW = $clog2(DM_WORDS);

  logic [AW-1:0]   word_idx;
  logic            misaligned;
  logic            mem_we;
  logic [XLEN-1:0] rdata;
  logic            unused_hi_addr;

  // Address bits above the array are ignored, so accesses alias.
  assign word_idx       = out_EX[AW+1:2];
  assign unused_hi_addr = ^out_EX[XLEN-1:AW+2];

  assign misaligned = (out_EX[1:0] != 2'b00) & (MemWrite_EX | MemtoReg_EX);
  assign mem_we     = MemWrite_EX & ~stall & ~misaligned & rst_n;

  data_mem #(
    .DM_WORDS(DM_WORDS),
    .AW      (AW)
  ) u_data_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (word_idx),
    .wdata(busB_EX),
    .rdata(rdata)
  );

  // rdata is the pre-write word on a store edge, giving read-before-write
  // semantics for a combined load/store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busW_WB     <= '0;
      RW_WB       <= '0;
      RegWrite_WB <= 1'b0;
    end else if (!stall) begin
      RW_WB <= RW_EX;
      if (MemtoReg_EX) begin
        busW_WB     <= misaligned ? '0 : rdata;
        RegWrite_WB <= RegWrite_EX & ~misaligned;
      end else begin
        busW_WB     <= out_EX;
        RegWrite_WB <= RegWrite_EX;
      end
    end
  end

  // Sticky; set even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          align_err <= 1'b0;
    else if (misaligned) align_err <= 1'b1;
  end

  assign branch_taken  = nPC_sel_EX & zero_EX & rst_n;
  assign branch_target = PCnew_EX;

  assign fwd_en_MEM   = RegWrite_EX & ~MemtoReg_EX & (RW_EX != '0);
  assign fwd_RW_MEM   = RW_EX;
  assign fwd_data_MEM = out_EX;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: behavioural reference model plus
// directed vectors with hand-computed literal expectations.
module tb_mem_wb_stage;

  localparam int unsigned DM_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] PCnew_EX = '0, out_EX = '0, busB_EX = '0;
  logic [4:0]  RW_EX = '0;
  logic        zero_EX = 1'b0, nPC_sel_EX = 1'b0, MemWrite_EX = 1'b0;
  logic        MemtoReg_EX = 1'b0, RegWrite_EX = 1'b0, stall = 1'b0;
  logic [31:0] busW_WB, branch_target, fwd_data_MEM;
  logic [4:0]  RW_WB, fwd_RW_MEM;
  logic        RegWrite_WB, branch_taken, fwd_en_MEM, align_err;

  mem_wb_stage #(.DM_WORDS(DM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .PCnew_EX(PCnew_EX), .out_EX(out_EX),
    .busB_EX(busB_EX), .RW_EX(RW_EX), .zero_EX(zero_EX),
    .nPC_sel_EX(nPC_sel_EX), .MemWrite_EX(MemWrite_EX),
    .MemtoReg_EX(MemtoReg_EX), .RegWrite_EX(RegWrite_EX), .stall(stall),
    .busW_WB(busW_WB), .RW_WB(RW_WB), .RegWrite_WB(RegWrite_WB),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .fwd_en_MEM(fwd_en_MEM), .fwd_RW_MEM(fwd_RW_MEM),
    .fwd_data_MEM(fwd_data_MEM), .align_err(align_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory as a plain array of words, addresses reduced
  // arithmetically; data of never-written words is treated as unknown.
  logic [31:0] mem_m [DM_WORDS];
  bit          known_m [DM_WORDS];
  logic [31:0] m_busw = '0;
  logic [4:0]  m_rw = '0;
  logic        m_rwe = 1'b0, m_aerr = 1'b0;
  bit          m_busw_known = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busw = '0; m_rw = '0; m_rwe = 1'b0; m_aerr = 1'b0; m_busw_known = 1'b1;
    end else begin
      int unsigned idx;
      bit mis;
      idx = (out_EX / 4) % DM_WORDS;
      mis = (out_EX % 4 != 0) && (MemWrite_EX || MemtoReg_EX);
      if (!stall) begin
        m_rw = RW_EX;
        if (MemtoReg_EX) begin
          if (mis) begin
            m_busw = '0; m_busw_known = 1'b1; m_rwe = 1'b0;
          end else begin
            m_busw = mem_m[idx]; m_busw_known = known_m[idx]; m_rwe = RegWrite_EX;
          end
        end else begin
          m_busw = out_EX; m_busw_known = 1'b1; m_rwe = RegWrite_EX;
        end
        if (MemWrite_EX && !mis) begin
          mem_m[idx] = busB_EX; known_m[idx] = 1'b1;
        end
      end
      if (mis) m_aerr = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      if (m_busw_known) chk("m_busW_WB", busW_WB, m_busw);
      chk("m_RW_WB", {27'd0, RW_WB}, {27'd0, m_rw});
      chk("m_RegWrite_WB", {31'd0, RegWrite_WB}, {31'd0, m_rwe});
      chk("m_align_err", {31'd0, align_err}, {31'd0, m_aerr});
      chk("m_branch_taken", {31'd0, branch_taken},
          {31'd0, nPC_sel_EX && zero_EX && rst_n});
      chk("m_branch_target", branch_target, PCnew_EX);
      chk("m_fwd_en", {31'd0, fwd_en_MEM},
          {31'd0, RegWrite_EX && !MemtoReg_EX && (RW_EX != 0)});
      chk("m_fwd_RW", {27'd0, fwd_RW_MEM}, {27'd0, RW_EX});
      chk("m_fwd_data", fwd_data_MEM, out_EX);
    end
  end

  task automatic drv(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rw,
                     input logic mw, input logic mr, input logic rwe, input logic st);
    out_EX = a; busB_EX = b; RW_EX = rw;
    MemWrite_EX = mw; MemtoReg_EX = mr; RegWrite_EX = rwe; stall = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    cmp_on = 1'b1;
    chk("rst_busW", busW_WB, 32'h0);
    chk("rst_RegWrite", {31'd0, RegWrite_WB}, 32'h0);
    chk("rst_align_err", {31'd0, align_err}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // store 0x10 <- DEADBEEF, then load into r5
    drv(32'h10, 32'hDEADBEEF, 5'd0, 1, 0, 0, 0); tick();
    drv(32'h10, 32'h0, 5'd5, 0, 1, 1, 0); tick();
    chk("ld_busW", busW_WB, 32'hDEADBEEF);
    chk("ld_RW", {27'd0, RW_WB}, 32'd5);
    chk("ld_RegWrite", {31'd0, RegWrite_WB}, 32'd1);

    // ALU pass-through with forwarding in the same cycle
    drv(32'h1234, 32'h0, 5'd3, 0, 0, 1, 0);
    #1;
    chk("fwd_en", {31'd0, fwd_en_MEM}, 32'd1);
    chk("fwd_data", fwd_data_MEM, 32'h1234);
    tick();
    chk("alu_busW", busW_WB, 32'h1234);

    // Stalled store to 0x20: latch holds, memory untouched
    drv(32'h20, 32'h11, 5'd0, 1, 0, 0, 0); tick();
    drv(32'h20, 32'h55, 5'd9, 1, 0, 1, 1); tick(); tick();
    chk("stall_busW", busW_WB, 32'h20);
    chk("stall_RW", {27'd0, RW_WB}, 32'd0);
    drv(32'h20, 32'h0, 5'd6, 0, 1, 1, 1); tick();
    chk("stall_mem_not_written_latch", busW_WB, 32'h20);
    drv(32'h20, 32'h0, 5'd6, 0, 1, 1, 0); tick();
    chk("stall_mem_old", busW_WB, 32'h11);
    drv(32'h20, 32'h55, 5'd0, 1, 0, 0, 0); tick();
    drv(32'h20, 32'h0, 5'd6, 0, 1, 1, 0); tick();
    chk("stall_then_store", busW_WB, 32'h55);

    // Misaligned store dropped, flag sticky
    drv(32'h22, 32'h99, 5'd0, 1, 0, 0, 0); tick();
    chk("mis_align_err", {31'd0, align_err}, 32'd1);
    drv(32'h20, 32'h0, 5'd6, 0, 1, 1, 0); tick();
    chk("mis_store_dropped", busW_WB, 32'h55);
    // Misaligned load: zero data, no write-back
    drv(32'h21, 32'h0, 5'd7, 0, 1, 1, 0); tick();
    chk("misld_busW", busW_WB, 32'h0);
    chk("misld_RegWrite", {31'd0, RegWrite_WB}, 32'd0);
    drv(32'h40, 32'h0, 5'd2, 0, 0, 1, 0); tick();
    chk("sticky_align_err", {31'd0, align_err}, 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_clears_align_err", {31'd0, align_err}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Misaligned access during stall still sets the flag
    drv(32'h23, 32'h0, 5'd1, 0, 1, 1, 1); tick();
    chk("stall_mis_align_err", {31'd0, align_err}, 32'd1);

    // Combined load+store: pre-write word captured, store lands
    drv(32'h30, 32'hA5A5A5A5, 5'd0, 1, 0, 0, 0); tick();
    drv(32'h30, 32'h5A5A5A5A, 5'd8, 1, 1, 1, 0); tick();
    chk("ldst_prewrite", busW_WB, 32'hA5A5A5A5);
    drv(32'h30, 32'h0, 5'd8, 0, 1, 1, 0); tick();
    chk("ldst_stored", busW_WB, 32'h5A5A5A5A);

    // Aliasing: high bits ignored
    drv(32'h10 + DM_WORDS * 4, 32'h0, 5'd4, 0, 1, 1, 0); tick();
    chk("alias", busW_WB, 32'hDEADBEEF);

    // RW=0 still propagates
    drv(32'h77, 32'h0, 5'd0, 0, 0, 1, 0);
    #1;
    chk("fwd_en_r0", {31'd0, fwd_en_MEM}, 32'd0);
    tick();
    chk("r0_RegWrite", {31'd0, RegWrite_WB}, 32'd1);
    chk("r0_busW", busW_WB, 32'h77);

    // Branch
    PCnew_EX = 32'h400; nPC_sel_EX = 1'b1; zero_EX = 1'b1; #1;
    chk("br_taken", {31'd0, branch_taken}, 32'd1);
    chk("br_target", branch_target, 32'h400);
    zero_EX = 1'b0; #1;
    chk("br_not_taken", {31'd0, branch_taken}, 32'd0);
    tick();
    zero_EX = 1'b1;

    // Async reset mid-cycle, store during reset is blocked
    drv(32'hCAFE, 32'h0, 5'd12, 0, 0, 1, 0); tick();
    chk("pre_rst_RegWrite", {31'd0, RegWrite_WB}, 32'd1);
    #1 rst_n = 1'b0; #1;
    chk("async_busW", busW_WB, 32'h0);
    chk("async_RegWrite", {31'd0, RegWrite_WB}, 32'd0);
    chk("async_RW", {27'd0, RW_WB}, 32'd0);
    chk("rst_branch_taken", {31'd0, branch_taken}, 32'd0);
    drv(32'h10, 32'hBAD0BAD0, 5'd0, 1, 0, 0, 0); tick();
    rst_n = 1'b1;
    nPC_sel_EX = 1'b0; zero_EX = 1'b0;
    drv(32'h10, 32'h0, 5'd5, 0, 1, 1, 0); tick();
    chk("rst_store_blocked", busW_WB, 32'hDEADBEEF);

    drv(32'h0, 32'h0, 5'd0, 0, 0, 0, 0); tick(); tick();
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL provide parameter: DM_WORDS, 256, data-memory depth in 32-bit words (power of two, 16..1024).
REQ-002 SHALL provide ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- PCnew_EX  in  32  branch target from the EX/MEM latch.
- out_EX  in  32  ALU result / byte address.
- busB_EX  in  32  store data.
- RW_EX  in  5  destination register.
- zero_EX  in  1  ALU zero flag.
- nPC_sel_EX  in  1  branch instruction.
- MemWrite_EX  in  1  store.
- MemtoReg_EX  in  1  load.
- RegWrite_EX  in  1  register write-back.
- stall  in  1  hold the MEM/WB latch and suppress the store.
- busW_WB  out  32  write-back data.
- RW_WB  out  5  write-back register.
- RegWrite_WB  out  1  write-back enable.
- branch_taken  out  1  redirect PC and flush IF/ID/EX.
- branch_target  out  32  redirect address.
- fwd_en_MEM  out  1  MEM-stage forward valid.
- fwd_RW_MEM  out  5  MEM-stage forward register.
- fwd_data_MEM  out  32  MEM-stage forward value.
- align_err  out  1  sticky misaligned-access flag.
REQ-003 SHALL use one clock (clk); reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 Word index SHALL be out_EX[log2(DM_WORDS)+1:2]; higher address bits are ignored, so addresses alias modulo DM_WORDS*4.
REQ-005 An access is misaligned when out_EX[1:0]!=0 and either MemWrite_EX or MemtoReg_EX is 1.
REQ-006 Store: on a rising edge with MemWrite_EX=1, stall=0, aligned, and rst_n=1, the word SHALL be written with busB_EX; otherwise memory is unchanged.
REQ-007 Load read SHALL be combinational from the array, so a store at edge N is visible to a load in cycle N+1.
REQ-008 MEM/WB latch, 1-cycle latency; on each rising edge with stall=0:
- busW_WB = MemtoReg_EX ? mem[index] : out_EX.
- RW_WB = RW_EX.
- RegWrite_WB = RegWrite_EX.
REQ-009 With stall=1 the MEM/WB latch SHALL hold all values.
REQ-010 A misaligned load SHALL capture busW_WB=0 with RegWrite_WB=0.
REQ-011 A misaligned store SHALL be dropped.
REQ-012 Any misaligned access SHALL set align_err on that edge (including when stall=1); align_err clears only on reset.
REQ-013 branch_taken SHALL equal nPC_sel_EX & zero_EX & rst_n, combinationally.
REQ-014 branch_target SHALL equal PCnew_EX, combinationally.
REQ-015 Forwarding outputs SHALL be combinational:
- fwd_en_MEM = RegWrite_EX & ~MemtoReg_EX & (RW_EX!=0).
- fwd_RW_MEM = RW_EX.
- fwd_data_MEM = out_EX.
REQ-016 RW_EX=0 SHALL still propagate to RW_WB; suppressing writes to register 0 belongs to the register file.
REQ-017 Simultaneous MemWrite_EX=1 and MemtoReg_EX=1 SHALL perform the store, and busW_WB SHALL capture the pre-write word.

Reset
REQ-018 While rst_n=0:
- busW_WB=0, RW_WB=0, RegWrite_WB=0, align_err=0.
- Stores are blocked.
- branch_taken=0.
REQ-019 Memory contents SHALL NOT be reset.
REQ-020 Reset asserted mid-operation SHALL clear the latch immediately (asynchronously), without waiting for clk.
REQ-021 The first capture after reset SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-022 Shared package mips_pkg SHALL hold the constants XLEN=32 and REG_ADDR_W=5.
REQ-023 Sub-module data_mem SHALL own the array, the synchronous write and the combinational read, and SHALL have no reset.
REQ-024 The MEM/WB latch, misalignment logic, branch logic and forwarding logic SHALL reside in mem_wb_stage.

Verification
REQ-025 Store then load: store out_EX=0x10, busB_EX=0xDEADBEEF; next cycle load 0x10 with RW_EX=5 -> following cycle busW_WB=0xDEADBEEF, RW_WB=5, RegWrite_WB=1.
REQ-026 ALU pass-through: out_EX=0x1234, MemtoReg_EX=0, RegWrite_EX=1, RW_EX=3 -> busW_WB=0x1234 one cycle later; same cycle fwd_en_MEM=1, fwd_data_MEM=0x1234.
REQ-027 Stall: stall=1 for 2 cycles during a store to 0x20 of 0x55 -> MEM/WB latch unchanged and memory unchanged; with stall=0 the store lands and a later load of 0x20 returns 0x55.
REQ-028 Misaligned access: store to 0x22 -> word 0x20 unchanged and align_err=1; after later clean traffic align_err stays 1, and a reset pulse clears it.
REQ-029 Branch: nPC_sel_EX=1, zero_EX=1, PCnew_EX=0x400 -> branch_taken=1 and branch_target=0x400 in the same cycle; with zero_EX=0 -> branch_taken=0.
REQ-030 Async reset: assert rst_n=0 between clock edges with RegWrite_WB=1 -> outputs go to 0 before the next edge; a store presented during reset does not modify memory.
